sisc_fetch_unit: RTL and testbench



---
 rtl/sisc_pkg.sv | 31 +++
 rtl/sisc_fetch_unit_if.sv | 29 ++
 rtl/sisc_fetch_unit_pc_next_calc.sv | 20 ++
 rtl/sisc_fetch_unit.sv | 138 +++++++++++++
 tb/tb_sisc_fetch_unit.sv | 378 +++++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/sisc_pkg.sv
// Shared SISC definitions: opcodes, instruction field positions and the fetch FSM states.
package sisc_pkg;

  localparam logic [3:0] NOOP   = 4'd0;
  localparam logic [3:0] LOD    = 4'd1;
  localparam logic [3:0] STR    = 4'd2;
  localparam logic [3:0] SWP    = 4'd3;
  localparam logic [3:0] BRA    = 4'd4;
  localparam logic [3:0] BRR    = 4'd5;
  localparam logic [3:0] BNE    = 4'd6;
  localparam logic [3:0] BNR    = 4'd7;
  localparam logic [3:0] ALU_OP = 4'd8;
  localparam logic [3:0] HLT    = 4'd15;

  localparam int OPCODE_MSB = 31;
  localparam int OPCODE_LSB = 28;
  localparam int MM_MSB     = 27;
  localparam int MM_LSB     = 24;
  localparam int IMM_MSB    = 15;
  localparam int IMM_LSB    = 0;

  // Wide enough for TIMEOUT values up to 255.
  localparam int WAIT_CNT_W = 8;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/sisc_fetch_unit_if.sv
// Instruction-memory port of the SISC fetch unit.
interface sisc_fetch_unit_if #(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32
);
  // req/ack handshake: the master raises imem_req with imem_addr and holds both
  // stable until it samples imem_ack high (or gives up on timeout); imem_rdata is
  // only meaningful in a cycle where imem_ack is high, and acks while imem_req is
  // low are ignored.
  logic               imem_req;
  logic [PC_W-1:0]    imem_addr;
  logic [INSTR_W-1:0] imem_rdata;
  logic               imem_ack;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_rdata,
    input  imem_ack
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_rdata,
    output imem_ack
  );

endinterface

// File: rtl/sisc_fetch_unit_pc_next_calc.sv
// Next-PC arithmetic: increment, absolute branch or relative branch, all modulo 2^PC_W.
module pc_next_calc #(
  parameter int PC_W = 16
) (
  input  logic [PC_W-1:0] pc,
  input  logic [15:0]     imm,
  input  logic            pc_sel,
  input  logic            br_sel,
  output logic [PC_W-1:0] pc_next
);

  always_comb begin
    pc_next = pc + PC_W'(1);
    if (pc_sel) begin
      if (br_sel) pc_next = PC_W'(imm);
      else        pc_next = pc + PC_W'($signed(imm));
    end
  end

endmodule

// File: rtl/sisc_fetch_unit.sv
// SISC instruction fetch stage: owns pc and ir, fetches over a bounded req/ack
// handshake and applies the controller's PC commands while idle.
module sisc_fetch_unit
  import sisc_pkg::*;
#(
  parameter int PC_W    = 16,
  parameter int INSTR_W = 32,
  parameter int TIMEOUT = 15
) (
  input  logic               clk,
  input  logic               rst_f,
  input  logic               ir_load,
  input  logic               pc_write,
  input  logic               pc_sel,
  input  logic               br_sel,
  input  logic               pc_rst,
  sisc_fetch_unit_if.master  imem,
  output logic [INSTR_W-1:0] ir,
  output logic [3:0]         opcode,
  output logic [3:0]         mm,
  output logic [15:0]        imm,
  output logic [PC_W-1:0]    pc,
  output logic               ir_valid,
  output logic               fetch_busy,
  output logic               fetch_err,
  output fetch_state_e       state_dbg
);

  localparam logic [WAIT_CNT_W-1:0] CNT_LAST = WAIT_CNT_W'(TIMEOUT - 1);

  fetch_state_e          state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic                  req_q, req_d;
  logic [PC_W-1:0]       addr_q, addr_d;
  logic [INSTR_W-1:0]    ir_q, ir_d;
  logic [PC_W-1:0]       pc_q, pc_d;
  logic                  err_q, err_d;

  logic                  calc_pc_sel;
  logic [PC_W-1:0]       pc_next;

  // Outside IDLE the only PC change is the fetch increment, so force pc+1 there.
  assign calc_pc_sel = (state_q == IDLE) && pc_sel;

  pc_next_calc #(.PC_W(PC_W)) u_pc_next_calc (
    .pc      (pc_q),
    .imm     (ir_q[IMM_MSB:IMM_LSB]),
    .pc_sel  (calc_pc_sel),
    .br_sel  (br_sel),
    .pc_next (pc_next)
  );

  always_ff @(posedge clk or negedge rst_f) begin
    if (!rst_f) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      req_q   <= 1'b0;
      addr_q  <= '0;
      ir_q    <= '0;
      pc_q    <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
      addr_q  <= addr_d;
      ir_q    <= ir_d;
      pc_q    <= pc_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    req_d   = req_q;
    addr_d  = addr_q;
    ir_d    = ir_q;
    pc_d    = pc_q;
    err_d   = err_q;

    if (pc_rst) begin
      state_d = IDLE;
      cnt_d   = '0;
      req_d   = 1'b0;
      addr_d  = '0;
      ir_d    = '0;
      pc_d    = '0;
      err_d   = 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (ir_load) begin
            req_d   = 1'b1;
            addr_d  = pc_q;
            cnt_d   = '0;
            state_d = WAIT;
          end else if (pc_write) begin
            pc_d = pc_next;
          end
        end
        WAIT: begin
          // An ack landing on the last allowed cycle still completes normally.
          if (imem.imem_ack) begin
            ir_d    = imem.imem_rdata;
            pc_d    = pc_next;
            req_d   = 1'b0;
            state_d = DONE;
          end else if (cnt_q == CNT_LAST) begin
            ir_d    = '0;
            err_d   = 1'b1;
            pc_d    = pc_next;
            req_d   = 1'b0;
            state_d = DONE;
          end else begin
            cnt_d = cnt_q + WAIT_CNT_W'(1);
          end
        end
        DONE: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  assign imem.imem_req  = req_q;
  assign imem.imem_addr = addr_q;

  assign ir         = ir_q;
  assign opcode     = ir_q[OPCODE_MSB:OPCODE_LSB];
  assign mm         = ir_q[MM_MSB:MM_LSB];
  assign imm        = ir_q[IMM_MSB:IMM_LSB];
  assign pc         = pc_q;
  assign ir_valid   = (state_q == DONE);
  assign fetch_busy = (state_q == WAIT) || (state_q == DONE);
  assign fetch_err  = err_q;
  assign state_dbg  = state_q;

endmodule

// File: tb/tb_sisc_fetch_unit.sv
// Self-checking bench for sisc_fetch_unit against a behavioural fetch/PC model.
module tb_sisc_fetch_unit;
  import sisc_pkg::*;

  localparam int PC_W    = 16;
  localparam int INSTR_W = 32;
  localparam int TO      = 4;

  // ---------------- clock / reset / DUT ----------------
  logic clk = 1'b0;
  logic rst_f = 1'b0;
  logic ir_load = 1'b0, pc_write = 1'b0, pc_sel = 1'b0, br_sel = 1'b0, pc_rst = 1'b0;
  logic [INSTR_W-1:0] ir;
  logic [3:0]         opcode, mm;
  logic [15:0]        imm;
  logic [PC_W-1:0]    pc;
  logic               ir_valid, fetch_busy, fetch_err;
  fetch_state_e       state_dbg;

  sisc_fetch_unit_if #(.PC_W(PC_W), .INSTR_W(INSTR_W)) imem ();

  sisc_fetch_unit #(.PC_W(PC_W), .INSTR_W(INSTR_W), .TIMEOUT(TO)) dut (
    .clk        (clk),
    .rst_f      (rst_f),
    .ir_load    (ir_load),
    .pc_write   (pc_write),
    .pc_sel     (pc_sel),
    .br_sel     (br_sel),
    .pc_rst     (pc_rst),
    .imem       (imem.master),
    .ir         (ir),
    .opcode     (opcode),
    .mm         (mm),
    .imm        (imm),
    .pc         (pc),
    .ir_valid   (ir_valid),
    .fetch_busy (fetch_busy),
    .fetch_err  (fetch_err),
    .state_dbg  (state_dbg)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- reference model ----------------
  int n_checks = 0;
  int n_errors = 0;
  logic [PC_W-1:0]    m_pc;
  logic [INSTR_W-1:0] m_ir;
  logic               m_err;

  function automatic void model_reset();
    m_pc = '0; m_ir = '0; m_err = 1'b0;
  endfunction

  // A fetch whose ack comes after d empty wait cycles succeeds only if d < TO.
  function automatic void model_fetch(input logic [31:0] data, input int d);
    if (d < TO) m_ir = data;
    else begin
      m_ir  = '0;
      m_err = 1'b1;
    end
    m_pc = m_pc + 16'd1;
  endfunction

  function automatic void model_pc_write(input logic sel, input logic br);
    if (!sel)    m_pc = m_pc + 16'd1;
    else if (br) m_pc = m_ir[15:0];
    else         m_pc = 16'(int'(m_pc) + int'($signed(m_ir[15:0])));
  endfunction

  function automatic int exp_req_cycles(input int d);
    return (d < TO) ? d + 1 : TO;
  endfunction

  // ---------------- driver tasks ----------------
  // Issues ir_load, acts as instruction memory (ack after d empty WAIT cycles), and
  // returns what it observed up to the first idle cycle after the fetch.
  task automatic run_fetch(input logic [31:0] data, input int d, input bit noise,
                           output int req_cycles, output logic [15:0] addr_first,
                           output bit addr_stable, output int valid_cnt, output int busy_cnt);
    req_cycles = 0; valid_cnt = 0; busy_cnt = 0; addr_stable = 1'b1; addr_first = '0;
    @(negedge clk);
    ir_load = 1'b1;
    if (noise) begin
      pc_write = 1'($urandom_range(0, 1));
      pc_sel   = 1'($urandom_range(0, 1));
      br_sel   = 1'($urandom_range(0, 1));
    end
    @(negedge clk);
    ir_load = 1'b0; pc_write = 1'b0;
    for (int c = 0; c < TO + 4; c++) begin
      if (!fetch_busy) break;
      if (imem.imem_req) begin
        if (req_cycles == 0) addr_first = imem.imem_addr;
        else if (imem.imem_addr !== addr_first) addr_stable = 1'b0;
        req_cycles++;
      end
      if (ir_valid) valid_cnt++;
      busy_cnt++;
      imem.imem_ack   = (c == d) || (noise && !imem.imem_req && $urandom_range(0, 1) == 1);
      imem.imem_rdata = (c == d) ? data : $urandom;
      if (noise) begin
        ir_load  = 1'($urandom_range(0, 1));
        pc_write = 1'($urandom_range(0, 1));
        pc_sel   = 1'($urandom_range(0, 1));
        br_sel   = 1'($urandom_range(0, 1));
      end
      @(negedge clk);
    end
    imem.imem_ack = 1'b0; ir_load = 1'b0; pc_write = 1'b0;
  endtask

  task automatic drive_pc_write(input logic sel, input logic br);
    @(negedge clk);
    pc_write = 1'b1; pc_sel = sel; br_sel = br;
    @(negedge clk);
    pc_write = 1'b0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst_f = 1'b0;
    imem.imem_ack = 1'b0; imem.imem_rdata = '0;
    repeat (3) @(negedge clk);
    rst_f = 1'b1;
    model_reset();
    @(negedge clk);
    n_checks++;
    if ({ir, pc, imem.imem_req, imem.imem_addr, ir_valid, fetch_busy, fetch_err} !== '0) begin
      n_errors++;
      $display("FAIL reset_outputs ir=%h pc=%h req=%b addr=%h valid=%b busy=%b err=%b expected all zero",
               ir, pc, imem.imem_req, imem.imem_addr, ir_valid, fetch_busy, fetch_err);
    end
    n_checks++;
    if (state_dbg !== IDLE) begin
      n_errors++; $display("FAIL reset_state got %0d exp %0d", state_dbg, IDLE);
    end
  endtask

  task automatic test_zero_wait();
    int rq, vc, bc; logic [15:0] a0; bit st;
    run_fetch(32'h8100_0005, 0, 1'b0, rq, a0, st, vc, bc);
    model_fetch(32'h8100_0005, 0);
    n_checks++;
    if ({ir, opcode, mm, imm, pc} !== {32'h8100_0005, 4'd8, 4'd1, 16'd5, 16'd1}) begin
      n_errors++;
      $display("FAIL zero_wait_fields ir=%h op=%h mm=%h imm=%h pc=%h exp 81000005/8/1/0005/0001",
               ir, opcode, mm, imm, pc);
    end
    n_checks++;
    if ({rq, vc, bc} !== {32'd1, 32'd1, 32'd2}) begin
      n_errors++;
      $display("FAIL zero_wait_timing req=%0d valid=%0d busy=%0d exp 1/1/2", rq, vc, bc);
    end
    n_checks++;
    if (a0 !== 16'h0000) begin
      n_errors++; $display("FAIL zero_wait_addr got %h exp 0000", a0);
    end
  endtask

  task automatic test_wait3();
    int rq, vc, bc; logic [15:0] a0, exp_addr; bit st;
    logic [31:0] data;
    data = $urandom;
    exp_addr = m_pc;
    run_fetch(data, 2, 1'b0, rq, a0, st, vc, bc);
    model_fetch(data, 2);
    n_checks++;
    if ({rq, vc, bc} !== {32'd3, 32'd1, 32'd4}) begin
      n_errors++;
      $display("FAIL wait3_timing req=%0d valid=%0d busy=%0d exp 3/1/4", rq, vc, bc);
    end
    n_checks++;
    if ({a0, st} !== {exp_addr, 1'b1}) begin
      n_errors++; $display("FAIL wait3_addr got %h stable=%b exp %h stable=1", a0, st, exp_addr);
    end
    n_checks++;
    if ({ir, pc, fetch_err} !== {m_ir, m_pc, m_err}) begin
      n_errors++;
      $display("FAIL wait3_result ir=%h pc=%h err=%b exp %h %h %b", ir, pc, fetch_err, m_ir, m_pc, m_err);
    end
  endtask

  task automatic test_ack_at_timeout();
    int rq, vc, bc; logic [15:0] a0; bit st;
    logic [31:0] data;
    data = $urandom;
    run_fetch(data, TO - 1, 1'b0, rq, a0, st, vc, bc);
    model_fetch(data, TO - 1);
    n_checks++;
    if ({ir, pc, fetch_err, rq} !== {m_ir, m_pc, 1'b0, TO}) begin
      n_errors++;
      $display("FAIL ack_at_timeout ir=%h pc=%h err=%b req=%0d exp %h %h 0 %0d",
               ir, pc, fetch_err, rq, m_ir, m_pc, TO);
    end
  endtask

  task automatic test_timeout();
    int rq, vc, bc; logic [15:0] a0; bit st;
    run_fetch(32'h1234_5678, TO + 1, 1'b0, rq, a0, st, vc, bc);
    model_fetch(32'h1234_5678, TO + 1);
    n_checks++;
    if ({ir, pc, fetch_err} !== {32'h0, m_pc, 1'b1}) begin
      n_errors++;
      $display("FAIL timeout_result ir=%h pc=%h err=%b exp 00000000 %h 1", ir, pc, fetch_err, m_pc);
    end
    n_checks++;
    if ({rq, vc, bc} !== {TO, 32'd1, TO + 1}) begin
      n_errors++;
      $display("FAIL timeout_timing req=%0d valid=%0d busy=%0d exp %0d/1/%0d", rq, vc, bc, TO, TO + 1);
    end
    @(negedge clk);
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hDEAD_BEEF;
    @(negedge clk);
    imem.imem_ack = 1'b0;
    n_checks++;
    if ({ir, imem.imem_req, state_dbg} !== {32'h0, 1'b0, IDLE}) begin
      n_errors++;
      $display("FAIL timeout_late_ack ir=%h req=%b state=%0d exp 00000000 0 IDLE",
               ir, imem.imem_req, state_dbg);
    end
  endtask

  task automatic test_pc_rst();
    @(negedge clk);
    pc_rst = 1'b1; ir_load = 1'b1; pc_write = 1'b1; pc_sel = 1'b0;
    #1;
    n_checks++;
    if (fetch_err !== 1'b1) begin
      n_errors++; $display("FAIL pc_rst_is_sync err=%b exp 1 before the edge", fetch_err);
    end
    @(negedge clk);
    pc_rst = 1'b0; ir_load = 1'b0; pc_write = 1'b0;
    model_reset();
    n_checks++;
    if ({ir, pc, fetch_err, imem.imem_req, state_dbg} !== {32'h0, 16'h0, 1'b0, 1'b0, IDLE}) begin
      n_errors++;
      $display("FAIL pc_rst_clear ir=%h pc=%h err=%b req=%b state=%0d exp all zero IDLE",
               ir, pc, fetch_err, imem.imem_req, state_dbg);
    end
    // pc_rst during WAIT beats a simultaneous ack.
    @(negedge clk);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0; pc_rst = 1'b1; imem.imem_ack = 1'b1; imem.imem_rdata = 32'hCAFE_F00D;
    @(negedge clk);
    pc_rst = 1'b0; imem.imem_ack = 1'b0;
    n_checks++;
    if ({ir, pc, imem.imem_req, state_dbg} !== {32'h0, 16'h0, 1'b0, IDLE}) begin
      n_errors++;
      $display("FAIL pc_rst_in_wait ir=%h pc=%h req=%b state=%0d exp 0 0 0 IDLE",
               ir, pc, imem.imem_req, state_dbg);
    end
  endtask

  task automatic test_branches();
    int rq, vc, bc; logic [15:0] a0; bit st;
    run_fetch(32'h4000_000F, 0, 1'b0, rq, a0, st, vc, bc); model_fetch(32'h4000_000F, 0);
    drive_pc_write(1'b1, 1'b1); model_pc_write(1'b1, 1'b1);
    n_checks++;
    if (pc !== 16'h000F) begin n_errors++; $display("FAIL br_abs_000f got %h exp 000f", pc); end
    run_fetch(32'h5000_FFFE, 1, 1'b0, rq, a0, st, vc, bc); model_fetch(32'h5000_FFFE, 1);
    n_checks++;
    if ({a0, pc} !== {16'h000F, 16'h0010}) begin
      n_errors++; $display("FAIL br_fetch_at_000f addr=%h pc=%h exp 000f 0010", a0, pc);
    end
    drive_pc_write(1'b1, 1'b0); model_pc_write(1'b1, 1'b0);
    n_checks++;
    if (pc !== 16'h000E) begin n_errors++; $display("FAIL br_rel_minus2 got %h exp 000e", pc); end
    run_fetch(32'h4000_0100, 0, 1'b0, rq, a0, st, vc, bc); model_fetch(32'h4000_0100, 0);
    drive_pc_write(1'b1, 1'b1); model_pc_write(1'b1, 1'b1);
    n_checks++;
    if (pc !== 16'h0100) begin n_errors++; $display("FAIL br_abs_0100 got %h exp 0100", pc); end
    run_fetch(32'h4000_FFFF, 0, 1'b0, rq, a0, st, vc, bc); model_fetch(32'h4000_FFFF, 0);
    drive_pc_write(1'b1, 1'b1); model_pc_write(1'b1, 1'b1);
    drive_pc_write(1'b0, 1'b0); model_pc_write(1'b0, 1'b0);
    n_checks++;
    if (pc !== 16'h0000) begin n_errors++; $display("FAIL inc_wrap got %h exp 0000", pc); end
    drive_pc_write(1'b1, 1'b1); model_pc_write(1'b1, 1'b1);
    run_fetch(32'h0000_0000, 0, 1'b0, rq, a0, st, vc, bc); model_fetch(32'h0, 0);
    n_checks++;
    if ({a0, pc} !== {16'hFFFF, 16'h0000}) begin
      n_errors++; $display("FAIL fetch_wrap addr=%h pc=%h exp ffff 0000", a0, pc);
    end
  endtask

  task automatic test_random();
    int rq, vc, bc, d, op; logic [15:0] a0, exp_addr; bit st;
    logic [31:0] data;
    logic s, b;
    for (int i = 0; i < 60; i++) begin
      op = $urandom_range(0, 3);
      if (op <= 1) begin
        data = $urandom;
        d = $urandom_range(0, TO + 1);
        exp_addr = m_pc;
        run_fetch(data, d, 1'b1, rq, a0, st, vc, bc);
        model_fetch(data, d);
        n_checks++;
        if ({rq, vc, bc, a0, st} !== {exp_req_cycles(d), 32'd1, exp_req_cycles(d) + 1, exp_addr, 1'b1}) begin
          n_errors++;
          $display("FAIL rand_fetch_hs it=%0d d=%0d req=%0d valid=%0d busy=%0d addr=%h stable=%b exp addr %h",
                   i, d, rq, vc, bc, a0, st, exp_addr);
        end
      end else if (op == 2) begin
        s = 1'($urandom_range(0, 1));
        b = 1'($urandom_range(0, 1));
        drive_pc_write(s, b);
        model_pc_write(s, b);
      end else begin
        @(negedge clk);
        imem.imem_ack = 1'b1; imem.imem_rdata = $urandom;
        @(negedge clk);
        imem.imem_ack = 1'b0;
      end
      n_checks++;
      if ({ir, opcode, mm, imm, pc, fetch_err} !==
          {m_ir, m_ir[31:28], m_ir[27:24], m_ir[15:0], m_pc, m_err}) begin
        n_errors++;
        $display("FAIL rand_state it=%0d op=%0d ir=%h pc=%h err=%b exp %h %h %b",
                 i, op, ir, pc, fetch_err, m_ir, m_pc, m_err);
      end
    end
  endtask

  task automatic test_reset_mid_wait();
    if (pc == 16'h0) drive_pc_write(1'b0, 1'b0);
    @(negedge clk);
    ir_load = 1'b1;
    @(negedge clk);
    ir_load = 1'b0;
    n_checks++;
    if (imem.imem_req !== 1'b1) begin
      n_errors++; $display("FAIL mid_wait_req_before got %b exp 1", imem.imem_req);
    end
    #2 rst_f = 1'b0;
    #1;
    n_checks++;
    if ({ir, pc, imem.imem_req, imem.imem_addr, ir_valid, fetch_busy, fetch_err} !== '0) begin
      n_errors++;
      $display("FAIL mid_wait_async_reset ir=%h pc=%h req=%b addr=%h valid=%b busy=%b err=%b exp all zero",
               ir, pc, imem.imem_req, imem.imem_addr, ir_valid, fetch_busy, fetch_err);
    end
    imem.imem_ack = 1'b1; imem.imem_rdata = 32'hBAD0_0BAD;
    @(negedge clk);
    rst_f = 1'b1;
    model_reset();
    repeat (2) @(negedge clk);
    imem.imem_ack = 1'b0;
    n_checks++;
    if ({ir, pc, imem.imem_req, state_dbg} !== {32'h0, 16'h0, 1'b0, IDLE}) begin
      n_errors++;
      $display("FAIL mid_wait_late_ack ir=%h pc=%h req=%b state=%0d exp 0 0 0 IDLE",
               ir, pc, imem.imem_req, state_dbg);
    end
  endtask

  initial begin
    test_reset();
    test_zero_wait();
    test_wait3();
    test_ack_at_timeout();
    test_timeout();
    test_pc_rst();
    test_branches();
    test_random();
    test_reset_mid_wait();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
